dac_axis_sink: RTL

- Synthesizable AXI4-stream slave: the receiving end of a DAC-side AXI4-stream master (valid/data handshake, per-stream transfer counter).
- Used for on-chip loopback and DSP-output verification in place of the RFDC DAC tile.
- Accepts samples under a programmable ready-throttle pattern.
- Counts accepted transfers and starvation gaps.
- Captures a triggered window of words into a BRAM, read back through a register/bram read port.

---
 rtl/dac_axis_sink.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dac_axis_sink.sv
// dac_axis_sink: AXI4-stream DAC-side sink with ready throttle, transfer/gap counters and a triggered capture buffer.
// Optional macro DAC_AXIS_SINK_TLAST_EN adds s_tlast-terminated capture and the lasterr counter.
module dac_axis_sink #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH_LOG2 = 10,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
`ifdef DAC_AXIS_SINK_TLAST_EN
  input  logic                  s_tlast,
`endif
  output logic                  s_tready,
  input  logic [15:0]           readypattern,
  input  logic                  stb_arm,
  input  logic                  trig,
  input  logic [DEPTH_LOG2:0]   caplen,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic [CNT_WIDTH-1:0]  gapcnt,
`ifdef DAC_AXIS_SINK_TLAST_EN
  output logic [CNT_WIDTH-1:0]  lasterr,
`endif
  output logic                  capdone,
  output logic [DEPTH_LOG2:0]   wrcount
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEN_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [15:0]             pattern_r;
  logic [15:0]             pat_src_s;
  logic                    tready_r;
  logic                    xfer_s;
  logic                    last_s;
  logic [CNT_WIDTH-1:0]    cnt_r;
  logic [CNT_WIDTH-1:0]    gap_r;
  logic                    seen_r;
  logic [DEPTH_LOG2:0]     wrcount_r;
  logic [DEPTH_LOG2:0]     wrcount_next_s;
  logic [DEPTH_LOG2:0]     wrcount_inc_s;
  logic [DEPTH_LOG2:0]     len_r;
  logic [DEPTH_LOG2:0]     len_next_s;
  logic [DEPTH_LOG2:0]     eff_len_s;
  logic                    capdone_r;
  logic                    capdone_next_s;
  logic                    wr_en_s;
  logic                    mem_we_s;
  logic [DEPTH_LOG2-1:0]   wr_addr_s;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

`ifdef DAC_AXIS_SINK_TLAST_EN
  logic [CNT_WIDTH-1:0]    lasterr_r;
  logic                    run_r;
  assign last_s = s_tlast;
`else
  assign last_s = 1'b0;
`endif

  assign xfer_s        = s_tvalid & tready_r;
  assign wrcount_inc_s = wrcount_r + LEN_ONE;
  assign mem_we_s      = wr_en_s & ~reset;

  // Pattern source: an arm strobe restarts the throttle sequence from the input pattern.
  always_comb begin
    pat_src_s = pattern_r;
    if (stb_arm) begin
      pat_src_s = readypattern;
    end else begin
      pat_src_s = pattern_r;
    end
  end

  // Ready throttle: rotate the pattern right each cycle, bit 0 drives s_tready.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_r <= readypattern;
      tready_r  <= 1'b0;
    end else begin
      pattern_r <= {pat_src_s[0], pat_src_s[15:1]};
      tready_r  <= pat_src_s[0];
    end
  end

  // Transfer counter (wrapping) and starvation counter (saturating, armed by the first transfer).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= {CNT_WIDTH{1'b0}};
      gap_r  <= {CNT_WIDTH{1'b0}};
      seen_r <= 1'b0;
    end else begin
      if (xfer_s) begin
        cnt_r  <= cnt_r + CNT_ONE;
        seen_r <= 1'b1;
      end
      if (seen_r && tready_r && !s_tvalid && (gap_r != CNT_MAX)) begin
        gap_r <= gap_r + CNT_ONE;
      end
    end
  end

  // Effective capture length: zero and oversize requests both mean a full buffer.
  always_comb begin
    eff_len_s = caplen;
    if ((caplen == {(DEPTH_LOG2+1){1'b0}}) || (caplen > FULL_LEN)) begin
      eff_len_s = FULL_LEN;
    end else begin
      eff_len_s = caplen;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      wrcount_r <= {(DEPTH_LOG2+1){1'b0}};
      capdone_r <= 1'b0;
      len_r     <= FULL_LEN;
    end else begin
      state_r   <= state_next_s;
      wrcount_r <= wrcount_next_s;
      capdone_r <= capdone_next_s;
      len_r     <= len_next_s;
    end
  end

  // Capture FSM next-state and write control; an arm strobe always wins over trigger and data.
  always_comb begin
    state_next_s   = state_r;
    wrcount_next_s = wrcount_r;
    capdone_next_s = capdone_r;
    len_next_s     = len_r;
    wr_en_s        = 1'b0;
    wr_addr_s      = wrcount_r[DEPTH_LOG2-1:0];
    case (state_r)
      ST_IDLE: begin
        if (stb_arm) begin
          state_next_s   = ST_ARMED;
          wrcount_next_s = {(DEPTH_LOG2+1){1'b0}};
          capdone_next_s = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (stb_arm) begin
          state_next_s   = ST_ARMED;
          wrcount_next_s = {(DEPTH_LOG2+1){1'b0}};
          capdone_next_s = 1'b0;
        end else if (trig) begin
          len_next_s = eff_len_s;
          if (xfer_s) begin
            wr_en_s        = 1'b1;
            wr_addr_s      = {DEPTH_LOG2{1'b0}};
            wrcount_next_s = LEN_ONE;
            if ((eff_len_s == LEN_ONE) || last_s) begin
              state_next_s   = ST_DONE;
              capdone_next_s = 1'b1;
            end else begin
              state_next_s = ST_CAPTURE;
            end
          end else begin
            state_next_s = ST_CAPTURE;
          end
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (stb_arm) begin
          state_next_s   = ST_ARMED;
          wrcount_next_s = {(DEPTH_LOG2+1){1'b0}};
          capdone_next_s = 1'b0;
        end else if (xfer_s) begin
          wr_en_s        = 1'b1;
          wr_addr_s      = wrcount_r[DEPTH_LOG2-1:0];
          wrcount_next_s = wrcount_inc_s;
          if ((wrcount_inc_s == len_r) || last_s) begin
            state_next_s   = ST_DONE;
            capdone_next_s = 1'b1;
          end else begin
            state_next_s = ST_CAPTURE;
          end
        end else begin
          state_next_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (stb_arm) begin
          state_next_s   = ST_ARMED;
          wrcount_next_s = {(DEPTH_LOG2+1){1'b0}};
          capdone_next_s = 1'b0;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        wrcount_next_s = {(DEPTH_LOG2+1){1'b0}};
        capdone_next_s = 1'b0;
      end
    endcase
  end

  // Capture buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_addr_s] <= s_tdata;
    end
  end

  // Registered read port; a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

`ifdef DAC_AXIS_SINK_TLAST_EN
  // Stray-tlast counter: a tlast outside capture that closes a run of at least one tlast-free word.
  always_ff @(posedge clk) begin
    if (reset) begin
      lasterr_r <= {CNT_WIDTH{1'b0}};
      run_r     <= 1'b0;
    end else begin
      if (xfer_s) begin
        run_r <= ~s_tlast;
      end
      if (xfer_s && s_tlast && (state_r != ST_CAPTURE) && run_r && (lasterr_r != CNT_MAX)) begin
        lasterr_r <= lasterr_r + CNT_ONE;
      end
    end
  end

  assign lasterr = lasterr_r;
`endif

  assign s_tready = tready_r;
  assign cnt      = cnt_r;
  assign gapcnt   = gap_r;
  assign capdone  = capdone_r;
  assign wrcount  = wrcount_r;
  assign rd_data  = rd_data_r;

endmodule
